// File: rtl/bus_cycle_ctrl.sv
// Round-robin CPU/DMA bus-cycle arbiter with per-cycle timeout (NXM); grant one clock after request.
// CPU stalls via memWAIT until its cycle is acknowledged or timed out; requesters cannot abort a granted cycle.
module bus_cycle_ctrl #(
  parameter int TMO = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic cpuREQ,
  input  logic cpuWR,
  input  logic dmaREQ,
  input  logic dmaWR,
  input  logic busACK,
  output logic busREQ,
  output logic busWR,
  output logic cpuGNT,
  output logic dmaGNT,
  output logic dmaDONE,
  output logic nxmERR,
  output logic memWAIT
);

  localparam int CW = $clog2(TMO);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_DMA,
    ST_NXM
  } state_t;

  generate
    if (TMO < 2 || TMO > 255) begin : g_bad_tmo
      $error("bus_cycle_ctrl: TMO must be in 2..255");
    end
  endgenerate

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          owner, owner_nxt;
  logic          last_win, last_win_nxt;
  logic          wr_flag, wr_flag_nxt;
  logic          grant_cpu, grant_dma;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      owner    <= OWN_CPU;
      wr_flag  <= 1'b0;
      last_win <= OWN_DMA;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      owner    <= owner_nxt;
      wr_flag  <= wr_flag_nxt;
      last_win <= last_win_nxt;
    end
  end

  // On a tie the requester that lost last time wins.
  always_comb begin
    grant_cpu = cpuREQ && (!dmaREQ || (last_win == OWN_DMA));
    grant_dma = dmaREQ && (!cpuREQ || (last_win == OWN_CPU));
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    owner_nxt    = owner;
    wr_flag_nxt  = wr_flag;
    last_win_nxt = last_win;

    case (state)
      ST_IDLE: begin
        if (grant_cpu) begin
          state_nxt    = ST_CPU;
          cnt_nxt      = '0;
          owner_nxt    = OWN_CPU;
          last_win_nxt = OWN_CPU;
          wr_flag_nxt  = cpuWR;
        end else if (grant_dma) begin
          state_nxt    = ST_DMA;
          cnt_nxt      = '0;
          owner_nxt    = OWN_DMA;
          last_win_nxt = OWN_DMA;
          wr_flag_nxt  = dmaWR;
        end
      end
      ST_CPU, ST_DMA: begin
        // Acknowledge wins over a coincident timeout.
        if (busACK) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_NXM;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_NXM: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busREQ  = (state == ST_CPU) || (state == ST_DMA);
    busWR   = busREQ && wr_flag;
    cpuGNT  = (state == ST_CPU);
    dmaGNT  = (state == ST_DMA);
    dmaDONE = (state == ST_DMA) && busACK;
    nxmERR  = (state == ST_NXM);
    memWAIT = cpuREQ && !(((state == ST_CPU) && busACK) ||
                          ((state == ST_NXM) && (owner == OWN_CPU)));
  end

  a_grant_excl : assert property (@(posedge clk) disable iff (rst) !(cpuGNT && dmaGNT));
  a_nxm_single : assert property (@(posedge clk) disable iff (rst) nxmERR |=> !nxmERR);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scenario bench for bus_cycle_ctrl: expected outputs queued per driven cycle, popped and compared at negedge.
module tb_bus_cycle_ctrl;

  localparam int T = 63;

  logic clk = 1'b0;
  logic rst, cpuREQ, cpuWR, dmaREQ, dmaWR, busACK;
  logic busREQ, busWR, cpuGNT, dmaGNT, dmaDONE, nxmERR, memWAIT;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic busreq;
    logic buswr;
    logic cpugnt;
    logic dmagnt;
    logic dmadone;
    logic nxmerr;
    logic memwait;
  } outs_t;

  outs_t exp_q[$];

  always #5 clk = ~clk;

  bus_cycle_ctrl #(.TMO(T)) dut (
    .clk(clk), .rst(rst),
    .cpuREQ(cpuREQ), .cpuWR(cpuWR), .dmaREQ(dmaREQ), .dmaWR(dmaWR), .busACK(busACK),
    .busREQ(busREQ), .busWR(busWR), .cpuGNT(cpuGNT), .dmaGNT(dmaGNT),
    .dmaDONE(dmaDONE), .nxmERR(nxmERR), .memWAIT(memWAIT)
  );

  function automatic outs_t mk(input logic rq, wr, cg, dg, dd, nx, mw);
    outs_t o;
    o.busreq = rq; o.buswr = wr; o.cpugnt = cg; o.dmagnt = dg;
    o.dmadone = dd; o.nxmerr = nx; o.memwait = mw;
    return o;
  endfunction

  function automatic outs_t observed();
    return mk(busREQ, busWR, cpuGNT, dmaGNT, dmaDONE, nxmERR, memWAIT);
  endfunction

  // busWR only carries meaning while a cycle is in progress.
  function automatic logic [6:0] care(input outs_t e);
    return e.busreq ? 7'h7F : 7'h5F;
  endfunction

  task automatic drive(input logic creq, cwr, dreq, dwr, ack);
    @(posedge clk);
    #1;
    cpuREQ = creq; cpuWR = cwr; dmaREQ = dreq; dmaWR = dwr; busACK = ack;
  endtask

  task automatic test_reset();
    outs_t e, got;
    rst = 1'b1; cpuREQ = 0; cpuWR = 0; dmaREQ = 0; dmaWR = 0; busACK = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      if (c == 2) rst = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, (c > 0)));
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b expected %b", c, got, e);
      end
    end
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = observed();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", got, e);
    end
  endtask

  task automatic test_cpu_write();
    outs_t e, got;
    for (int c = 0; c <= 4; c++) begin
      case (c)
        0:       begin drive(1, 1, 0, 0, 0); e = mk(0, 0, 0, 0, 0, 0, 1); end
        1, 2:    begin drive(1, 1, 0, 0, 0); e = mk(1, 1, 1, 0, 0, 0, 1); end
        3:       begin drive(1, 1, 0, 0, 1); e = mk(1, 1, 1, 0, 0, 0, 0); end
        default: begin drive(0, 0, 0, 0, 0); e = mk(0, 0, 0, 0, 0, 0, 0); end
      endcase
      exp_q.push_back(e);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      checks++;
      if (((got ^ e) & care(e)) !== 7'b0) begin
        errors++;
        $display("FAIL cpu_write cyc%0d: got %b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    outs_t e, got;
    for (int c = 0; c <= 6; c++) begin
      case (c)
        0:       begin drive(1, 0, 0, 0, 0); e = mk(0, 0, 0, 0, 0, 0, 1); end
        1:       begin drive(1, 0, 1, 1, 1); e = mk(1, 0, 1, 0, 0, 0, 0); end
        2, 4:    begin drive(1, 0, 1, 1, 0); e = mk(0, 0, 0, 0, 0, 0, 1); end
        3:       begin drive(1, 0, 1, 1, 1); e = mk(1, 1, 0, 1, 1, 0, 1); end
        5:       begin drive(0, 0, 0, 0, 1); e = mk(1, 0, 1, 0, 0, 0, 0); end
        default: begin drive(0, 0, 0, 0, 0); e = mk(0, 0, 0, 0, 0, 0, 0); end
      endcase
      exp_q.push_back(e);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      checks++;
      if (((got ^ e) & care(e)) !== 7'b0) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_round_robin();
    outs_t e, got;
    int done_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) begin
        drive(0, 0, 0, 0, 0);
        e = mk(0, 0, 0, 0, 0, 0, 0);
      end else begin
        drive(1, 1, 1, 0, (i % 2 == 1));
        if (i % 2 == 0)      e = mk(0, 0, 0, 0, 0, 0, 1);
        else if (i % 4 == 1) e = mk(1, 1, 1, 0, 0, 0, 0);
        else                 e = mk(1, 0, 0, 1, 1, 0, 1);
      end
      rst = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      got = observed();
      if (got.dmadone) done_cnt++;
      e = exp_q.pop_front();
      checks++;
      if (((got ^ e) & care(e)) !== 7'b0) begin
        errors++;
        $display("FAIL round_robin cyc%0d: got %b expected %b", i, got, e);
      end
    end
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL round_robin_done_count: got %0d expected 2", done_cnt);
    end
  endtask

  task automatic test_dma_drop();
    outs_t e, got;
    for (int c = 0; c <= 5; c++) begin
      case (c)
        0:       begin drive(0, 0, 1, 1, 0); e = mk(0, 0, 0, 0, 0, 0, 0); end
        1:       begin drive(0, 0, 1, 1, 0); e = mk(1, 1, 0, 1, 0, 0, 0); end
        2, 3:    begin drive(0, 0, 0, 0, 0); e = mk(1, 1, 0, 1, 0, 0, 0); end
        4:       begin drive(0, 0, 0, 0, 1); e = mk(1, 1, 0, 1, 1, 0, 0); end
        default: begin drive(0, 0, 0, 0, 0); e = mk(0, 0, 0, 0, 0, 0, 0); end
      endcase
      exp_q.push_back(e);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      checks++;
      if (((got ^ e) & care(e)) !== 7'b0) begin
        errors++;
        $display("FAIL dma_drop cyc%0d: got %b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_timeout();
    outs_t e, got;
    for (int c = 0; c <= T + 4; c++) begin
      if (c == 0) begin
        drive(1, 0, 0, 0, 0); e = mk(0, 0, 0, 0, 0, 0, 1);
      end else if (c <= T) begin
        drive(1, 0, 0, 0, 0); e = mk(1, 0, 1, 0, 0, 0, 1);
      end else if (c == T + 1) begin
        drive(1, 0, 0, 0, 1); e = mk(0, 0, 0, 0, 0, 1, 0);
      end else if (c == T + 2) begin
        drive(1, 0, 0, 0, 1); e = mk(0, 0, 0, 0, 0, 0, 1);
      end else if (c == T + 3) begin
        drive(0, 0, 0, 0, 1); e = mk(1, 0, 1, 0, 0, 0, 0);
      end else begin
        drive(0, 0, 0, 0, 0); e = mk(0, 0, 0, 0, 0, 0, 0);
      end
      exp_q.push_back(e);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      checks++;
      if (((got ^ e) & care(e)) !== 7'b0) begin
        errors++;
        $display("FAIL timeout cyc%0d: got %b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_ack_at_limit();
    outs_t e, got;
    for (int c = 0; c <= T + 2; c++) begin
      if (c == 0) begin
        drive(0, 0, 1, 1, 0); e = mk(0, 0, 0, 0, 0, 0, 0);
      end else if (c < T) begin
        drive(0, 0, 1, 1, 0); e = mk(1, 1, 0, 1, 0, 0, 0);
      end else if (c == T) begin
        drive(0, 0, 1, 1, 1); e = mk(1, 1, 0, 1, 1, 0, 0);
      end else begin
        drive(0, 0, 0, 0, 0); e = mk(0, 0, 0, 0, 0, 0, 0);
      end
      exp_q.push_back(e);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      checks++;
      if (((got ^ e) & care(e)) !== 7'b0) begin
        errors++;
        $display("FAIL ack_at_limit cyc%0d: got %b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    outs_t e, got;
    for (int c = 0; c <= 14 + T + 1; c++) begin
      if (c == 14 + T + 1) drive(0, 0, 0, 0, 0);
      else                 drive(1, 1, 0, 0, 0);
      rst = (c == 11 || c == 12);
      if (c == 0 || (c >= 11 && c <= 13)) e = mk(0, 0, 0, 0, 0, 0, 1);
      else if (c < 11)                    e = mk(1, 1, 1, 0, 0, 0, 1);
      else if (c < 14 + T)                e = mk(1, 1, 1, 0, 0, 0, 1);
      else if (c == 14 + T)               e = mk(0, 0, 0, 0, 0, 1, 0);
      else                                e = mk(0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(e);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      checks++;
      if (((got ^ e) & care(e)) !== 7'b0) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: got %b expected %b", c, got, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cpu_write();
    test_back_to_back();
    test_round_robin();
    test_dma_drop();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
